// File: rtl/fmc_adc_acq_pkg.sv
// Shared types and constants for the FMC-ADC acquisition sequencer.
// State codes are also what the CSR STA.FSM field reports.
package fmc_adc_acq_pkg;

   localparam int unsigned c_TAG_WORDS = 4;
   localparam int unsigned c_CFG_W     = 32;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd1,
      ST_PRE_TRIG  = 3'd2,
      ST_WAIT_TRIG = 3'd3,
      ST_POST_TRIG = 3'd4,
      ST_TAG_WRITE = 3'd5,
      ST_DECR_SHOT = 3'd6
   } t_acq_fsm_state;

   typedef struct packed {
      logic [c_CFG_W-1:0] pre;
      logic [c_CFG_W-1:0] post;
   } t_acq_cfg;

endpackage

// File: rtl/fmc_adc_acq_cnt.sv
// Loadable down-counter; last_c flags the final count so the FSM can leave
// a state on the same cycle it consumes the last item.
module fmc_adc_acq_cnt #(
   parameter int unsigned g_W = 32
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           load_i,
   input  logic [g_W-1:0] load_val_i,
   input  logic           dec_i,
   output logic [g_W-1:0] count_o,
   output logic           last_c
);

   always_ff @(posedge clk_i) begin
      if (rst_i)       count_o <= '0;
      else if (load_i) count_o <= load_val_i;
      else if (dec_i)  count_o <= count_o - g_W'(1);
   end

   assign last_c = (count_o == g_W'(1));

endmodule

// File: rtl/fmc_adc_acq_seq.sv
// Multi-shot acquisition sequencer: pre/post-trigger sample storage strobes,
// trigger marker, timetag write slots and the end-of-acquisition event.
module fmc_adc_acq_seq
   import fmc_adc_acq_pkg::*;
#(
   parameter int unsigned g_ADDR_W    = 27,
   parameter int unsigned g_SHOTS_W   = 16,
   parameter int unsigned g_TAG_WORDS = c_TAG_WORDS
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic [31:0]          pre_samples_i,
   input  logic [31:0]          post_samples_i,
   input  logic [g_SHOTS_W-1:0] shots_i,
   input  logic                 sample_valid_i,
   input  logic                 trig_i,
   output logic                 acq_wr_o,
   output logic                 acq_trig_o,
   output logic                 acq_tag_o,
   output logic [g_ADDR_W-1:0]  wr_addr_o,
   output logic [g_ADDR_W-1:0]  trig_pos_o,
   output logic [g_SHOTS_W-1:0] shots_left_o,
   output logic [2:0]           fsm_state_o,
   output logic                 cfg_ok_o,
   output logic                 acq_end_o
);

   localparam int unsigned c_TAG_CNT_W = $clog2(g_TAG_WORDS) + 1;

   t_acq_fsm_state         state_q, state_d;
   t_acq_cfg               cfg_q;
   logic                   pend_q, pend_d;
   logic [g_ADDR_W-1:0]    ptr_q;
   logic [c_TAG_CNT_W-1:0] tag_cnt_q, tag_cnt_d;
   logic                   wr_d, trig_d, tag_d, end_d;
   logic                   adv_c, trig_ld_c, cfg_ld_c;
   logic                   pre_ld_c, post_ld_c, pre_dec_c, post_dec_c, shots_dec_c;
   logic [c_CFG_W-1:0]     pre_val_c, post_val_c;
   logic                   pre_last_c, post_last_c, shots_last_c;
   logic [c_CFG_W-1:0]     pre_cnt, post_cnt;
   logic                   unused_cnt;

   assign fsm_state_o = state_q;
   assign unused_cnt  = ^{pre_cnt, post_cnt};

   fmc_adc_acq_cnt #(.g_W(c_CFG_W)) u_pre_cnt (
      .clk_i(clk_i), .rst_i(rst_i), .load_i(pre_ld_c), .load_val_i(pre_val_c),
      .dec_i(pre_dec_c), .count_o(pre_cnt), .last_c(pre_last_c)
   );

   fmc_adc_acq_cnt #(.g_W(c_CFG_W)) u_post_cnt (
      .clk_i(clk_i), .rst_i(rst_i), .load_i(post_ld_c), .load_val_i(post_val_c),
      .dec_i(post_dec_c), .count_o(post_cnt), .last_c(post_last_c)
   );

   fmc_adc_acq_cnt #(.g_W(g_SHOTS_W)) u_shots_cnt (
      .clk_i(clk_i), .rst_i(rst_i), .load_i(cfg_ld_c), .load_val_i(shots_i),
      .dec_i(shots_dec_c), .count_o(shots_left_o), .last_c(shots_last_c)
   );

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state, strobes and counter controls; stop wins over everything
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      tag_cnt_d   = '0;
      wr_d        = 1'b0;
      trig_d      = 1'b0;
      tag_d       = 1'b0;
      end_d       = 1'b0;
      adv_c       = 1'b0;
      trig_ld_c   = 1'b0;
      cfg_ld_c    = 1'b0;
      pre_ld_c    = 1'b0;
      post_ld_c   = 1'b0;
      pre_dec_c   = 1'b0;
      post_dec_c  = 1'b0;
      shots_dec_c = 1'b0;
      pre_val_c   = cfg_q.pre;
      post_val_c  = cfg_q.post;
      if (stop_i && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         pend_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               pend_d = 1'b0;
               if (start_i && cfg_ok_o) begin
                  cfg_ld_c   = 1'b1;
                  pre_ld_c   = 1'b1;
                  post_ld_c  = 1'b1;
                  pre_val_c  = pre_samples_i;
                  post_val_c = post_samples_i;
                  state_d    = (pre_samples_i == '0) ? ST_WAIT_TRIG : ST_PRE_TRIG;
               end
            end
            ST_PRE_TRIG: if (sample_valid_i) begin
               wr_d      = 1'b1;
               adv_c     = 1'b1;
               pre_dec_c = 1'b1;
               if (pre_last_c) state_d = ST_WAIT_TRIG;
            end
            ST_WAIT_TRIG: begin
               if (sample_valid_i) begin
                  wr_d  = 1'b1;
                  adv_c = 1'b1;
                  if (trig_i || pend_q) begin
                     trig_d    = 1'b1;
                     trig_ld_c = 1'b1;
                     pend_d    = 1'b0;
                     state_d   = ST_POST_TRIG;
                  end
               end else if (trig_i) begin
                  pend_d = 1'b1;
               end
            end
            ST_POST_TRIG: if (sample_valid_i) begin
               wr_d       = 1'b1;
               adv_c      = 1'b1;
               post_dec_c = 1'b1;
               if (post_last_c) state_d = ST_TAG_WRITE;
            end
            ST_TAG_WRITE: begin
               tag_d     = 1'b1;
               adv_c     = 1'b1;
               tag_cnt_d = tag_cnt_q + c_TAG_CNT_W'(1);
               if (tag_cnt_q == c_TAG_CNT_W'(g_TAG_WORDS - 1)) begin
                  tag_cnt_d = '0;
                  state_d   = ST_DECR_SHOT;
               end
            end
            ST_DECR_SHOT: begin
               shots_dec_c = 1'b1;
               if (shots_last_c) begin
                  end_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  pre_ld_c  = 1'b1;
                  post_ld_c = 1'b1;
                  state_d   = (cfg_q.pre == '0) ? ST_WAIT_TRIG : ST_PRE_TRIG;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Registered outputs and write pointer; wr_addr_o shows the slot being written
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_q     <= 1'b0;
         tag_cnt_q  <= '0;
         ptr_q      <= '0;
         cfg_q      <= '0;
         cfg_ok_o   <= 1'b0;
         acq_wr_o   <= 1'b0;
         acq_trig_o <= 1'b0;
         acq_tag_o  <= 1'b0;
         acq_end_o  <= 1'b0;
         wr_addr_o  <= '0;
         trig_pos_o <= '0;
      end else begin
         pend_q     <= pend_d;
         tag_cnt_q  <= tag_cnt_d;
         cfg_ok_o   <= (post_samples_i != '0) && (shots_i != '0);
         acq_wr_o   <= wr_d;
         acq_trig_o <= trig_d;
         acq_tag_o  <= tag_d;
         acq_end_o  <= end_d;
         if (cfg_ld_c) cfg_q <= '{pre: pre_samples_i, post: post_samples_i};
         if (adv_c) begin
            wr_addr_o <= ptr_q;
            ptr_q     <= ptr_q + g_ADDR_W'(1);
         end
         if (trig_ld_c) trig_pos_o <= ptr_q;
      end
   end

endmodule

// File: tb/tb_fmc_adc_acq_seq.sv
// Randomized scoreboard bench for fmc_adc_acq_seq.
module tb_fmc_adc_acq_seq;

   localparam int unsigned AW   = 27;
   localparam int unsigned SW   = 16;
   localparam int unsigned NTAG = 4;

   typedef struct {
      logic          wr;
      logic          trig;
      logic          tag;
      logic          endp;
      logic [AW-1:0] addr;
      logic [SW-1:0] shots;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1, start_i = 1'b0, stop_i = 1'b0;
   logic [31:0]   pre_samples_i = 32'd0, post_samples_i = 32'd1;
   logic [SW-1:0] shots_i = SW'(1);
   logic          sample_valid_i = 1'b0, trig_i = 1'b0;
   logic          acq_wr_o, acq_trig_o, acq_tag_o, cfg_ok_o, acq_end_o;
   logic [AW-1:0] wr_addr_o, trig_pos_o;
   logic [SW-1:0] shots_left_o;
   logic [2:0]    fsm_state_o;

   int            n_cmp = 0;
   int            n_err = 0;
   ev_t           exp_q[$];
   logic [AW-1:0] mptr = '0;

   fmc_adc_acq_seq dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
      .pre_samples_i(pre_samples_i), .post_samples_i(post_samples_i), .shots_i(shots_i),
      .sample_valid_i(sample_valid_i), .trig_i(trig_i),
      .acq_wr_o(acq_wr_o), .acq_trig_o(acq_trig_o), .acq_tag_o(acq_tag_o),
      .wr_addr_o(wr_addr_o), .trig_pos_o(trig_pos_o), .shots_left_o(shots_left_o),
      .fsm_state_o(fsm_state_o), .cfg_ok_o(cfg_ok_o), .acq_end_o(acq_end_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit rb(input int n);
      return ($urandom_range(0, n) == 0);
   endfunction

   // Apply one cycle of inputs; returns just after the consuming edge
   task automatic step(input bit sv, input bit trg, input bit st, input bit sp, input bit rs);
      sample_valid_i = sv; trig_i = trg; start_i = st; stop_i = sp; rst_i = rs;
      @(posedge clk); #1;
      sample_valid_i = 1'b0; trig_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic noise(input int n);
      repeat (n) step(rb(1), rb(1), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic push_ev(input bit wr, input bit trg, input bit tag, input bit en, input int rem);
      ev_t e;
      e.wr = wr; e.trig = trg; e.tag = tag; e.endp = en;
      e.addr = mptr; e.shots = SW'(rem);
      if (wr || tag) mptr = mptr + AW'(1);
      exp_q.push_back(e);
   endtask

   // One acquisition as the storage path should see it: pre, ring, trigger, post, tags
   task automatic do_acq(input int pre, input int post, input int shots, input int ring,
                         input int gap, input int mode, input bit chk_wait);
      pre_samples_i = 32'(pre); post_samples_i = 32'(post); shots_i = SW'(shots);
      idle(2);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("start_state", 32'(fsm_state_o), (pre == 0) ? 32'd3 : 32'd2);
      pre_samples_i  = 32'($urandom_range(0, 6));
      post_samples_i = 32'($urandom_range(0, 6));
      shots_i        = SW'($urandom_range(0, 3));
      for (int s = 0; s < shots; s++) begin
         int rem;
         rem = shots - s;
         for (int i = 0; i < pre; i++) begin
            repeat ($urandom_range(0, 2)) step(1'b0, rb(2), 1'b0, 1'b0, 1'b0);
            step(1'b1, (i == pre - 1) ? 1'b1 : rb(2), 1'b0, 1'b0, 1'b0);
            push_ev(1'b1, 1'b0, 1'b0, 1'b0, rem);
         end
         if (chk_wait && s == 0) begin
            idle(3);
            chk("wait_after_pre", 32'(fsm_state_o), 32'd3);
         end
         for (int i = 0; i < ring; i++) begin
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            push_ev(1'b1, 1'b0, 1'b0, 1'b0, rem);
         end
         idle(gap);
         if (mode == 1 || (mode == 0 && rb(1))) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         end else begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) step(1'b0, rb(1), 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         end
         push_ev(1'b1, 1'b1, 1'b0, 1'b0, rem);
         for (int i = 0; i < post; i++) begin
            repeat ($urandom_range(0, 2)) step(1'b0, rb(1), 1'b0, 1'b0, 1'b0);
            step(1'b1, rb(1), 1'b0, 1'b0, 1'b0);
            push_ev(1'b1, 1'b0, 1'b0, 1'b0, rem);
         end
         repeat (NTAG) push_ev(1'b0, 1'b0, 1'b1, 1'b0, rem);
         if (s == shots - 1) push_ev(1'b0, 1'b0, 1'b0, 1'b1, 0);
         noise(NTAG + 1);
      end
   endtask

   // Monitor: every strobe/event the DUT presents must match the queue head
   always @(negedge clk) begin
      ev_t e;
      logic ok;
      if (acq_wr_o === 1'b1 || acq_trig_o === 1'b1 || acq_tag_o === 1'b1 || acq_end_o === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL spurious_event: wr=%b trig=%b tag=%b end=%b addr=%0h, expected no event",
                     acq_wr_o, acq_trig_o, acq_tag_o, acq_end_o, wr_addr_o);
         end else begin
            e  = exp_q.pop_front();
            ok = (acq_wr_o === e.wr) && (acq_trig_o === e.trig) && (acq_tag_o === e.tag) &&
                 (acq_end_o === e.endp) && (shots_left_o === e.shots);
            if (e.wr || e.tag) ok = ok && (wr_addr_o === e.addr);
            if (e.trig)        ok = ok && (trig_pos_o === e.addr);
            if (e.endp)        ok = ok && (fsm_state_o === 3'd1);
            if (!ok) begin
               n_err++;
               $display("FAIL event: got wr=%b trig=%b tag=%b end=%b addr=%0h tpos=%0h shots=%0d st=%0d; expected wr=%b trig=%b tag=%b end=%b addr=%0h shots=%0d",
                        acq_wr_o, acq_trig_o, acq_tag_o, acq_end_o, wr_addr_o, trig_pos_o,
                        shots_left_o, fsm_state_o, e.wr, e.trig, e.tag, e.endp, e.addr, e.shots);
            end
         end
      end
   end

   initial begin
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_state", 32'(fsm_state_o), 32'd1);
      chk("rst_wr", 32'(acq_wr_o), 32'd0);
      chk("rst_trig", 32'(acq_trig_o), 32'd0);
      chk("rst_tag", 32'(acq_tag_o), 32'd0);
      chk("rst_end", 32'(acq_end_o), 32'd0);
      chk("rst_addr", 32'(wr_addr_o), 32'd0);
      chk("rst_tpos", 32'(trig_pos_o), 32'd0);
      chk("rst_shots", 32'(shots_left_o), 32'd0);
      chk("rst_cfg_ok", 32'(cfg_ok_o), 32'd0);
      rst_i = 1'b0;

      // invalid configurations never start
      post_samples_i = 32'd0; shots_i = SW'(1);
      idle(2);
      chk("cfg_post0", 32'(cfg_ok_o), 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      chk("post0_state", 32'(fsm_state_o), 32'd1);
      post_samples_i = 32'd3; shots_i = SW'(0);
      idle(2);
      chk("cfg_shots0", 32'(cfg_ok_o), 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      chk("shots0_state", 32'(fsm_state_o), 32'd1);

      do_acq(0, 1, 1, 0, 20, 2, 1'b0);   // single shot, trigger after 200 ns
      do_acq(2, 3, 3, 1, 50, 0, 1'b0);   // three shots
      do_acq(4, 8, 1, 0, 5, 2, 1'b1);    // trigger with last pre sample is dropped
      do_acq(1, 2, 1, 2, 0, 1, 1'b0);    // trigger and sample in the same cycle

      // stop during POST_TRIG
      pre_samples_i = 32'd1; post_samples_i = 32'd5; shots_i = SW'(2);
      idle(2);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); push_ev(1'b1, 1'b0, 1'b0, 1'b0, 2);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); push_ev(1'b1, 1'b1, 1'b0, 1'b0, 2);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); push_ev(1'b1, 1'b0, 1'b0, 1'b0, 2);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("stop_state", 32'(fsm_state_o), 32'd1);
      noise(4);
      chk("stop_stays_idle", 32'(fsm_state_o), 32'd1);

      // reset in the middle of the tag burst
      pre_samples_i = 32'd0; post_samples_i = 32'd2; shots_i = SW'(1);
      idle(2);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); push_ev(1'b1, 1'b1, 1'b0, 1'b0, 1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); push_ev(1'b1, 1'b0, 1'b0, 1'b0, 1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); push_ev(1'b1, 1'b0, 1'b0, 1'b0, 1);
      push_ev(1'b0, 1'b0, 1'b1, 1'b0, 1);
      push_ev(1'b0, 1'b0, 1'b1, 1'b0, 1);
      noise(2);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      mptr = '0;
      chk("mrst_state", 32'(fsm_state_o), 32'd1);
      chk("mrst_tag", 32'(acq_tag_o), 32'd0);
      chk("mrst_addr", 32'(wr_addr_o), 32'd0);
      chk("mrst_shots", 32'(shots_left_o), 32'd0);
      chk("mrst_cfg_ok", 32'(cfg_ok_o), 32'd0);
      noise(6);

      for (int k = 0; k < 20; k++) begin
         noise(3);
         do_acq($urandom_range(0, 5), $urandom_range(1, 6), $urandom_range(1, 3),
                $urandom_range(0, 3), $urandom_range(0, 4), 0, 1'b0);
      end

      idle(20);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
